// File: rtl/alu_bist_pkg.sv
// -----------------------------------------------------------------------------
// alu_bist_pkg
// Shared definitions for the ALU built-in self-test driver:
//   alu_op_t      - 3-bit ALU opcode encoding driven on alu_opcode
//   bist_state_t  - sequencing states of the driver FSM
//   LFSR_TAPS     - feedback mask of the 32-bit Fibonacci LFSR (taps 32,22,2,1)
//   lfsr_next()   - one LFSR step: shift left, XOR of tapped bits enters bit 0
// -----------------------------------------------------------------------------
package alu_bist_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_MUL = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_FINISH = 3'd4
    } bist_state_t;

    // Tap n maps to bit n-1: bits 31, 21, 1 and 0.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        return {cur[30:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/alu_bist_ref_model.sv
// -----------------------------------------------------------------------------
// alu_bist_ref_model
// Combinational golden model of the ALU under test.
//   opcode  in  3         operation (alu_op_t encoding)
//   a, b    in  DATA_W    operands, zero-extended to 2*DATA_W before use
//   result  out 2*DATA_W  expected result; SUB wraps modulo 2^(2*DATA_W),
//                         shifts use only b[2:0] as the shift amount
// -----------------------------------------------------------------------------
module alu_bist_ref_model
    import alu_bist_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [2:0]          opcode,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [2*DATA_W-1:0] result
);

    localparam int RW = 2 * DATA_W;

    logic [RW-1:0] a_ext;
    logic [RW-1:0] b_ext;

    assign a_ext = {{DATA_W{1'b0}}, a};
    assign b_ext = {{DATA_W{1'b0}}, b};

    always_comb begin
        result = '0;
        case (alu_op_t'(opcode))
            OP_ADD:  result = a_ext + b_ext;
            OP_SUB:  result = a_ext - b_ext;
            OP_AND:  result = a_ext & b_ext;
            OP_OR:   result = a_ext | b_ext;
            OP_XOR:  result = a_ext ^ b_ext;
            OP_MUL:  result = a_ext * b_ext;
            OP_SHL:  result = a_ext << b[2:0];
            OP_SHR:  result = a_ext >> b[2:0];
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_bist_driver.sv
// -----------------------------------------------------------------------------
// alu_bist_driver
// Drives LFSR-generated operand sets into an ALU over a valid/ready handshake,
// compares each returned result against a golden model and reports a summary.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begin a run (ignored while busy)
//   busy                run in progress
//   done                one-cycle pulse at end of run
//   pass                last completed run had zero errors
//   err_count           mismatches + timeouts + spurious results, saturating
//   tx_count            transactions checked in this run
//   alu_in_valid/ready  operand handshake toward the ALU
//   alu_opcode/a/b      operands, stable while alu_in_valid is waiting
//   alu_out_valid       single-cycle result strobe from the ALU
//   alu_result          ALU result
//   first_err_result    actual result of the first failing transaction
//
// Build option: define ALU_BIST_FIRST_ERR_EN to capture first_err_result;
// otherwise the output is tied to zero and no capture register exists.
// -----------------------------------------------------------------------------
module alu_bist_driver
    import alu_bist_pkg::*;
#(
    parameter int          DATA_W  = 8,
    parameter int          NUM_TX  = 256,
    parameter logic [31:0] SEED    = 32'hACE1_1234,
    parameter int          TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [15:0]         err_count,
    output logic [15:0]         tx_count,
    output logic                alu_in_valid,
    input  logic                alu_in_ready,
    output logic [2:0]          alu_opcode,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    input  logic                alu_out_valid,
    input  logic [2*DATA_W-1:0] alu_result,
    output logic [2*DATA_W-1:0] first_err_result
);

    localparam int RW   = 2 * DATA_W;
    localparam int TO_W = $clog2(TIMEOUT + 1);

    bist_state_t     state_reg;
    logic [31:0]     lfsr_reg;
    logic [RW-1:0]   expected_reg;
    logic [RW-1:0]   result_reg;
    logic            timed_out_reg;
    logic [TO_W-1:0] timeout_cnt_reg;

    logic [RW-1:0]   ref_result;
    logic [31:0]     op_src;
    logic            spurious;
    logic            tx_err;
    logic            last_tx;
    logic [1:0]      err_inc;
    logic [16:0]     err_sum;
    logic [15:0]     err_next;

    alu_bist_ref_model #(
        .DATA_W (DATA_W)
    ) u_ref_model (
        .opcode (alu_opcode),
        .a      (alu_a),
        .b      (alu_b),
        .result (ref_result)
    );

    always_comb begin
        // Operands for the next DRIVE: a fresh run starts from SEED directly,
        // later transactions use the LFSR as stepped at the last acceptance.
        op_src   = (state_reg == ST_IDLE) ? SEED : lfsr_reg;
        // A result strobe outside WAIT is an error only while a run is in
        // progress; counters stay frozen in IDLE so the last run stays readable.
        spurious = alu_out_valid && (state_reg != ST_WAIT) && (state_reg != ST_IDLE);
        tx_err   = (state_reg == ST_CHECK) && (timed_out_reg || (result_reg != expected_reg));
        // A spurious strobe can land on a CHECK cycle that also fails, so the
        // increment may be two.
        err_inc  = {1'b0, spurious} + {1'b0, tx_err};
        err_sum  = {1'b0, err_count} + {15'd0, err_inc};
        err_next = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        last_tx  = (tx_count == 16'(NUM_TX - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            lfsr_reg        <= SEED;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            tx_count        <= '0;
            alu_in_valid    <= 1'b0;
            alu_opcode      <= '0;
            alu_a           <= '0;
            alu_b           <= '0;
            expected_reg    <= '0;
            result_reg      <= '0;
            timed_out_reg   <= 1'b0;
            timeout_cnt_reg <= '0;
        end else begin
            err_count <= err_next;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        lfsr_reg     <= SEED;
                        err_count    <= '0;
                        tx_count     <= '0;
                        pass         <= 1'b0;
                        busy         <= 1'b1;
                        alu_opcode   <= op_src[2:0];
                        alu_a        <= op_src[DATA_W+2:3];
                        alu_b        <= op_src[2*DATA_W+2:DATA_W+3];
                        alu_in_valid <= 1'b1;
                        state_reg    <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    // alu_in_valid is always high here, so ready alone is the handshake.
                    if (alu_in_ready) begin
                        expected_reg    <= ref_result;
                        lfsr_reg        <= lfsr_next(lfsr_reg);
                        alu_in_valid    <= 1'b0;
                        timeout_cnt_reg <= '0;
                        state_reg       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Result is tested first so it wins over a same-cycle expiry.
                    if (alu_out_valid) begin
                        result_reg    <= alu_result;
                        timed_out_reg <= 1'b0;
                        state_reg     <= ST_CHECK;
                    end else if (timeout_cnt_reg == TO_W'(TIMEOUT - 1)) begin
                        result_reg    <= '0;
                        timed_out_reg <= 1'b1;
                        state_reg     <= ST_CHECK;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + TO_W'(1);
                    end
                end
                ST_CHECK: begin
                    tx_count <= tx_count + 16'd1;
                    if (last_tx) begin
                        done      <= 1'b1;
                        pass      <= (err_next == 16'd0);
                        state_reg <= ST_FINISH;
                    end else begin
                        alu_opcode   <= op_src[2:0];
                        alu_a        <= op_src[DATA_W+2:3];
                        alu_b        <= op_src[2*DATA_W+2:DATA_W+3];
                        alu_in_valid <= 1'b1;
                        state_reg    <= ST_DRIVE;
                    end
                end
                ST_FINISH: begin
                    done      <= 1'b0;
                    // Re-evaluated so a spurious strobe in this cycle still clears pass.
                    pass      <= (err_next == 16'd0);
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_BIST_FIRST_ERR_EN
    logic          first_err_seen_reg;
    logic [RW-1:0] first_err_reg;

    // result_reg is zero for a timeout, so timeouts capture zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_err_seen_reg <= 1'b0;
            first_err_reg      <= '0;
        end else if ((state_reg == ST_IDLE) && start) begin
            first_err_seen_reg <= 1'b0;
            first_err_reg      <= '0;
        end else if (tx_err && !first_err_seen_reg) begin
            first_err_seen_reg <= 1'b1;
            first_err_reg      <= result_reg;
        end
    end

    assign first_err_result = first_err_reg;
`else
    assign first_err_result = '0;
`endif

endmodule

// File: tb/tb_alu_bist_driver.sv
// -----------------------------------------------------------------------------
// tb_alu_bist_driver
// Bench for alu_bist_driver with a behavioural ALU responder whose latency,
// operand hold-off, ADD corruption, silence and spurious strobes are set per
// run. Expected operands come from an LFSR sequence generated up front, and
// expected results, error counts and run lengths from plain arithmetic.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_alu_bist_driver;

    localparam int DW   = 8;
    localparam int RW   = 2 * DW;
    localparam int NTX  = 16;
    localparam int TO   = 8;
    localparam logic [31:0] SEED_V = 32'hACE1_1234;

    localparam int M_OK      = 0;
    localparam int M_BAD_ADD = 1;
    localparam int M_NEVER   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, pass;
    logic [15:0]   err_count, tx_count;
    logic          alu_in_valid;
    logic          alu_in_ready = 1'b0;
    logic [2:0]    alu_opcode;
    logic [DW-1:0] alu_a, alu_b;
    logic          alu_out_valid = 1'b0;
    logic [RW-1:0] alu_result = '0;
    logic [RW-1:0] first_err_result;

    int checks = 0;
    int errors = 0;

    // Responder configuration, written by the main sequence between runs.
    int mode = M_OK;
    int latency = 3;
    int hold_idx = -1;
    int hold_cycles = 0;
    int spur_idx = -1;
    int tx_idx = 0;
    int done_seen = 0;

    longint unsigned ref_op [NTX];
    longint unsigned ref_a  [NTX];
    longint unsigned ref_b  [NTX];

    alu_bist_driver #(
        .DATA_W  (DW),
        .NUM_TX  (NTX),
        .SEED    (SEED_V),
        .TIMEOUT (TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .tx_count         (tx_count),
        .alu_in_valid     (alu_in_valid),
        .alu_in_ready     (alu_in_ready),
        .alu_opcode       (alu_opcode),
        .alu_a            (alu_a),
        .alu_b            (alu_b),
        .alu_out_valid    (alu_out_valid),
        .alu_result       (alu_result),
        .first_err_result (first_err_result)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_seen++;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint unsigned golden(input longint unsigned op,
                                               input longint unsigned a,
                                               input longint unsigned b);
        longint unsigned mask = (64'd1 << RW) - 1;
        longint unsigned r;
        case (op)
            0:       r = a + b;
            1:       r = a - b;
            2:       r = a & b;
            3:       r = a | b;
            4:       r = a ^ b;
            5:       r = a * b;
            6:       r = a << (b % 8);
            default: r = a >> (b % 8);
        endcase
        return r & mask;
    endfunction

    // Operand sequence: Fibonacci LFSR with taps 32,22,2,1, stepped once per transaction.
    task automatic build_reference();
        logic [31:0] s = SEED_V;
        logic fb;
        longint unsigned v;
        for (int i = 0; i < NTX; i++) begin
            v = longint'(s);
            ref_op[i] = v % 8;
            ref_a[i]  = (v / 8) % (64'd1 << DW);
            ref_b[i]  = (v / (64'd1 << (DW + 3))) % (64'd1 << DW);
            fb = s[31] ^ s[21] ^ s[1] ^ s[0];
            s  = {s[30:0], fb};
        end
    endtask

    // Behavioural ALU: acts once per falling edge.
    initial begin : responder
        int phase = 0;
        int hold_left = 0;
        int wait_left = 0;
        logic [2:0]    snap_op = '0;
        logic [DW-1:0] snap_a = '0, snap_b = '0;
        longint unsigned res = 0;
        forever begin
            @(negedge clk);
            alu_out_valid = 1'b0;
            if (rst) begin
                phase = 0;
                alu_in_ready = 1'b0;
            end else begin
                case (phase)
                    0: if (alu_in_valid) begin
                        if (tx_idx < NTX) begin
                            check_val($sformatf("opcode[%0d]", tx_idx), 64'(alu_opcode), ref_op[tx_idx]);
                            check_val($sformatf("a[%0d]", tx_idx), 64'(alu_a), ref_a[tx_idx]);
                            check_val($sformatf("b[%0d]", tx_idx), 64'(alu_b), ref_b[tx_idx]);
                        end else begin
                            check_val("extra_tx", 64'(tx_idx), 64'(NTX - 1));
                        end
                        snap_op = alu_opcode;
                        snap_a  = alu_a;
                        snap_b  = alu_b;
                        if (tx_idx == spur_idx) begin
                            alu_out_valid = 1'b1;
                            alu_result    = '1;
                        end
                        hold_left = (tx_idx == hold_idx) ? hold_cycles : 0;
                        if (hold_left == 0) begin
                            alu_in_ready = 1'b1;
                            phase = 2;
                        end else begin
                            hold_left--;
                            phase = 1;
                        end
                    end
                    1: begin
                        check_val("hold_stable", 64'({alu_in_valid, alu_opcode, alu_a, alu_b}),
                                  64'({1'b1, snap_op, snap_a, snap_b}));
                        if (hold_left == 0) begin
                            alu_in_ready = 1'b1;
                            phase = 2;
                        end else begin
                            hold_left--;
                        end
                    end
                    2: begin
                        alu_in_ready = 1'b0;
                        check_val("one_accept", 64'(alu_in_valid), 64'd0);
                        tx_idx++;
                        res = golden(64'(snap_op), 64'(snap_a), 64'(snap_b));
                        if (mode == M_BAD_ADD && snap_op == 3'd0) res = res ^ 64'd1;
                        if (mode == M_NEVER) begin
                            phase = 0;
                        end else if (latency <= 1) begin
                            alu_out_valid = 1'b1;
                            alu_result    = RW'(res);
                            phase = 0;
                        end else begin
                            wait_left = latency - 1;
                            phase = 3;
                        end
                    end
                    default: begin
                        wait_left--;
                        if (wait_left == 0) begin
                            alu_out_valid = 1'b1;
                            alu_result    = RW'(res);
                            phase = 0;
                        end
                    end
                endcase
            end
        end
    end

    task automatic run_and_check(input string name, input int m, input int lat,
                                 input int hidx, input int hcyc, input int sidx);
        int exp_err = 0;
        longint unsigned exp_first = 0;
        bit found = 0;
        int cyc;
        int exp_cyc;
        mode = m; latency = lat; hold_idx = hidx; hold_cycles = hcyc; spur_idx = sidx; tx_idx = 0;
        for (int i = 0; i < NTX; i++) begin
            if (m == M_BAD_ADD && ref_op[i] == 0) begin
                exp_err++;
                if (!found) begin
                    found = 1;
                    exp_first = golden(0, ref_a[i], ref_b[i]) ^ 64'd1;
                end
            end
        end
        if (m == M_NEVER) exp_err = NTX;
        if (sidx >= 0 && sidx < NTX) exp_err++;
        // Each transaction is one DRIVE, lat WAIT and one CHECK cycle, plus any hold-off.
        exp_cyc = 1 + NTX * (lat + 2) + ((hidx >= 0 && hidx < NTX) ? hcyc : 0);

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        check_val({name, ":run_len"}, 64'(cyc), 64'(exp_cyc));
        check_val({name, ":tx_count"}, 64'(tx_count), 64'(NTX));
        check_val({name, ":err_count"}, 64'(err_count), 64'(exp_err));
        check_val({name, ":pass"}, 64'(pass), 64'(exp_err == 0));
        check_val({name, ":busy_at_done"}, 64'(busy), 64'd1);
`ifdef ALU_BIST_FIRST_ERR_EN
        check_val({name, ":first_err"}, 64'(first_err_result), exp_first);
`else
        check_val({name, ":first_err"}, 64'(first_err_result), 64'd0);
`endif
        @(negedge clk);
        check_val({name, ":done_pulse"}, 64'({done, busy}), 64'd0);
        check_val({name, ":err_hold"}, 64'({pass, err_count}), 64'({exp_err == 0, 16'(exp_err)}));
        $display("run %s mode=%0d lat=%0d hold=%0d/%0d spur=%0d cycles=%0d err=%0d pass=%0d",
                 name, m, lat, hidx, hcyc, sidx, cyc, err_count, pass);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int guard;
        int done_before;
        build_reference();

        repeat (3) @(negedge clk);
        check_val("reset_outputs",
                  64'({busy, done, pass, alu_in_valid, alu_opcode, alu_a, alu_b}), 64'd0);
        check_val("reset_counts", 64'({err_count, tx_count}), 64'd0);
        check_val("reset_first_err", 64'(first_err_result), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_and_check("basic", M_OK, 3, -1, 0, -1);
        run_and_check("hold10", M_OK, $urandom_range(1, 5), $urandom_range(0, NTX - 1), 10, -1);
        run_and_check("bad_add", M_BAD_ADD, $urandom_range(1, TO), -1, 0, -1);
        run_and_check("no_result", M_NEVER, TO, -1, 0, -1);
        run_and_check("edge_timeout", M_OK, TO, -1, 0, -1);
        run_and_check("spurious", M_OK, 2, -1, 0, $urandom_range(0, NTX - 1));

        // Abort during WAIT of transaction 5, then replay from SEED.
        mode = M_OK; latency = 3; hold_idx = -1; spur_idx = -1; tx_idx = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        guard = 0;
        while (tx_idx != 5 && guard < 2000) begin
            @(negedge clk); #1;
            guard++;
        end
        check_val("abort_reached_tx5", 64'(tx_idx), 64'd5);
        done_before = done_seen;
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        check_val("abort_outputs", 64'({alu_in_valid, busy, done}), 64'd0);
        check_val("abort_counts", 64'({err_count, tx_count}), 64'd0);
        repeat (20) @(negedge clk);
        check_val("abort_no_done", 64'(done_seen), 64'(done_before));
        run_and_check("replay", M_OK, 3, -1, 0, -1);

        for (int r = 0; r < 3; r++) begin
            run_and_check($sformatf("rand%0d", r), int'($urandom_range(0, 1)),
                          int'($urandom_range(1, TO)), int'($urandom_range(0, NTX - 1)),
                          int'($urandom_range(0, 5)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_bist_driver.md
ALU_BIST_DRIVER -- requirements
Module: alu_bist_driver

Interface
REQ-001 SHALL have parameter DATA_W, default 8, ALU operand width; legal range 4..14.
REQ-002 SHALL have parameter NUM_TX, default 256, transactions per run; legal range 1..65535.
REQ-003 SHALL have parameter SEED, default 32'hACE1_1234, LFSR load value; must be nonzero.
REQ-004 SHALL have parameter TIMEOUT, default 64, max cycles from input accept to result.
REQ-005 SHALL have ports, one clock, reset synchronous and active-high:
  clk  in  1  clock
  rst  in  1  synchronous reset, active high
  start  in  1  begin run (pulse)
  busy  out  1  run in progress
  done  out  1  one-cycle pulse at end of run
  pass  out  1  last run had zero errors
  err_count  out  16  mismatches plus timeouts plus spurious results, saturating
  tx_count  out  16  transactions checked this run
  alu_in_valid  out  1  operands valid toward ALU
  alu_in_ready  in  1  ALU accepts operands
  alu_opcode  out  3  operation
  alu_a, alu_b  out  DATA_W  operands
  alu_out_valid  in  1  ALU result valid (single-cycle pulse)
  alu_result  in  2*DATA_W  ALU result
  first_err_result  out  2*DATA_W  actual result of first failing transaction

Function
REQ-006 SHALL run FSM states IDLE, DRIVE, WAIT, CHECK, FINISH.
REQ-007 SHALL in IDLE, on start=1, reload LFSR with SEED, clear err_count/tx_count, go DRIVE; busy=1 in every state except IDLE.
REQ-008 SHALL in DRIVE hold alu_in_valid=1 with stable opcode/a/b until the cycle alu_in_valid&&alu_in_ready, then go WAIT and clear timeout counter.
REQ-009 SHALL source operands from a 32-bit Fibonacci LFSR, taps 32,22,2,1: opcode=lfsr[2:0], a=lfsr[DATA_W+2:3], b=lfsr[2*DATA_W+2:DATA_W+3]; LFSR steps once per accepted transaction.
REQ-010 SHALL latch expected result at acceptance from the golden model: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6 SHL by b[2:0], 7 SHR by b[2:0]; operands zero-extended to 2*DATA_W, SUB wraps modulo 2^(2*DATA_W).
REQ-011 SHALL in WAIT, on alu_out_valid, register alu_result and go CHECK; if TIMEOUT cycles elapse without it, count one error and go CHECK flagged as timeout.
REQ-012 SHALL give alu_out_valid priority when it coincides with the timeout-expiry cycle.
REQ-013 SHALL in CHECK increment tx_count, increment err_count on mismatch, then go FINISH if tx_count reaches NUM_TX, else DRIVE.
REQ-014 SHALL count alu_out_valid in any state other than WAIT as one spurious error.
REQ-015 SHALL in FINISH pulse done for one cycle, set pass=(err_count==0), return IDLE; pass and counters hold until next start.
REQ-016 SHALL ignore start while busy=1.
REQ-017 SHALL saturate err_count at 16'hFFFF.

Reset
REQ-018 SHALL on rst=1 at a clk edge enter IDLE and zero busy, done, pass, err_count, tx_count, alu_in_valid, alu_opcode, alu_a, alu_b, first_err_result; LFSR loads SEED.
REQ-019 SHALL abort a run when reset is asserted mid-run: alu_in_valid low on the cycle after the reset edge, no done pulse.

Configuration
REQ-020 SHALL, with ALU_BIST_FIRST_ERR_EN defined, capture alu_result of the first erroring transaction of each run into first_err_result (zero for timeouts), cleared at start.
REQ-021 SHALL, without ALU_BIST_FIRST_ERR_EN, tie first_err_result to zero and synthesise no capture register.

Structure
REQ-022 SHALL place opcode enum (3-bit), FSM state enum and LFSR tap constant in shared package alu_bist_pkg.
REQ-023 SHALL implement the golden model as combinational sub-module alu_bist_ref_model.

Verification
REQ-024 Correct ALU responding 3 cycles after accept, NUM_TX=16 -> done after all 16, tx_count=16, err_count=0, pass=1.
REQ-025 ALU holding alu_in_ready=0 for 10 cycles -> alu_in_valid and operands stable all 10 cycles, single acceptance.
REQ-026 ALU returning result XOR 1 for every ADD -> err_count equals number of opcode-0 transactions, pass=0; with macro, first_err_result = first wrong ADD value.
REQ-027 ALU never asserting alu_out_valid, TIMEOUT=8, NUM_TX=4 -> each transaction takes 8 WAIT cycles, err_count=4, pass=0.
REQ-028 Result arriving exactly on timeout-expiry cycle -> counted as a result, no timeout error.
REQ-029 rst pulsed during WAIT of transaction 5, then start -> no done from aborted run; new run replays SEED sequence from first operand.
